ray_dispatcher: RTL and testbench
=================================

RAY_DISPATCHER -- requirements
Module: ray_dispatcher

Interface
REQ-001 SHALL have parameter WIDTH, default 1280, meaning frame width in pixels (pixel_h range 0..WIDTH-1).
REQ-002 SHALL have parameter HEIGHT, default 720, meaning frame height in pixels (pixel_v range 0..HEIGHT-1).
REQ-003 SHALL have parameter NUM_CORES, default 4, meaning number of ray-tracer cores served (2..16).
REQ-004 SHALL have port clk  input  1  sole clock; all logic is posedge.
REQ-005 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-006 SHALL have port start  input  1  single-cycle frame start request.
REQ-007 SHALL have port abort  input  1  cancels the current frame.
REQ-008 SHALL have port core_ready  input  NUM_CORES  core i can accept a pixel job.
REQ-009 SHALL have port core_idle  input  NUM_CORES  core i has no job in flight.
REQ-010 SHALL have port issue_valid  output  NUM_CORES  one-hot (or zero) job offer to core i.
REQ-011 SHALL have port pixel_h  output  11  offered job column.
REQ-012 SHALL have port pixel_v  output  10  offered job row.
REQ-013 SHALL have port busy  output  1  high outside IDLE.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse when the frame completes.

Function
REQ-015 SHALL implement states IDLE, ISSUE, DRAIN.
REQ-016 IDLE: start=1 -> ISSUE next cycle; coordinate counter loaded (0,0).
REQ-017 Scan order SHALL be column-major: pixel_v increments each accepted job; at HEIGHT-1 it wraps to 0 and pixel_h increments; last job is (WIDTH-1,HEIGHT-1).
REQ-018 Transfer SHALL occur on the cycle issue_valid[i] & core_ready[i]; at most one transfer per cycle.
REQ-019 An offer (issue_valid, pixel_h, pixel_v) SHALL remain stable until accepted; no retargeting of a pending offer.
REQ-020 A new offer SHALL be registered whenever no offer is pending or the pending one transfers this cycle, targeting the next core with core_ready=1 in round-robin order after the last granted core; none ready -> issue_valid=0.
REQ-021 Sustained all-ready SHALL yield one job per cycle, first offer visible one cycle after entering ISSUE.
REQ-022 Transfer of (WIDTH-1,HEIGHT-1) -> DRAIN; issue_valid=0 from the next cycle.
REQ-023 DRAIN: when core_idle is all ones -> frame_done=1 for one cycle, state IDLE in that same cycle's update.
REQ-024 start while busy SHALL be ignored.
REQ-025 abort in ISSUE or DRAIN -> IDLE next cycle, issue_valid cleared, no frame_done; abort and start together: abort wins.
REQ-026 Round-robin pointer SHALL persist across frames (not reset by start).

Reset
REQ-027 rst_n=0 SHALL asynchronously force: state IDLE, issue_valid=0, pixel_h=0, pixel_v=0, busy=0, frame_done=0, RR pointer = NUM_CORES-1 (core 0 first), frame_cycles=0.
REQ-028 Reset mid-frame SHALL discard all progress; deassertion is synchronized externally.

Configuration
REQ-029 With RAY_DISPATCH_PERF_EN defined, SHALL add output frame_cycles (32 bits): cleared on start acceptance, incremented every cycle while busy, held after frame_done or abort, saturates at all ones.
REQ-030 Without RAY_DISPATCH_PERF_EN, port frame_cycles and its counter SHALL not exist.

Structure
REQ-031 Shared package rtx_pkg SHALL hold the state enum (IDLE/ISSUE/DRAIN), PIX_H_W=11, PIX_V_W=10.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, last-grant pointer in, one-hot grant out, combinational).

Verification (WIDTH=4, HEIGHT=3, NUM_CORES=2 unless noted)
REQ-033 All ready, start -> 12 transfers in 12 consecutive cycles, order (0,0),(0,1),(0,2),(1,0)..(3,2), grants alternate core0,core1; frame_done 1 cycle after core_idle=11.
REQ-034 core_ready[1]=0 throughout -> every job to core 0, offers held while core_ready[0] toggles, no job lost or duplicated.
REQ-035 Hold core_idle=01 after last transfer -> busy=1, no frame_done; raise to 11 -> exactly one frame_done pulse.
REQ-036 abort after 5th transfer -> issue_valid=0 next cycle, busy=0, no frame_done; new start restarts at (0,0).
REQ-037 rst_n low mid-ISSUE (async, between edges) -> outputs at reset values immediately; start during ISSUE ignored.
REQ-038 With RAY_DISPATCH_PERF_EN, all ready/idle -> frame_cycles = 14 after frame_done and held.

Source files
------------

// File: rtl/rtx_pkg.sv
// Shared definitions for the ray dispatcher slice: FSM state type and
// pixel coordinate widths.
package rtx_pkg;

  localparam int unsigned PIX_H_W = 11;
  localparam int unsigned PIX_V_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly
// after last_ptr, wrapping around; one-hot grant, all zero when idle.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] last_ptr,
  output logic [N-1:0]     grant
);

  logic        found;
  int unsigned idx;

  // Scan requesters starting one past the last grant.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = (int'(last_ptr) + off) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ray_dispatcher.sv
// Ray dispatcher: walks a WIDTHxHEIGHT frame in column-major order and
// offers one pixel job at a time to NUM_CORES ray-tracer cores using
// round-robin selection, then waits for all cores to go idle.
// Optional feature macro: RAY_DISPATCH_PERF_EN adds the frame_cycles
// busy-cycle counter output.
module ray_dispatcher
  import rtx_pkg::*;
#(
  parameter int unsigned WIDTH     = 1280,
  parameter int unsigned HEIGHT    = 720,
  parameter int unsigned NUM_CORES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_CORES-1:0] core_ready,
  input  logic [NUM_CORES-1:0] core_idle,
  output logic [NUM_CORES-1:0] issue_valid,
  output logic [PIX_H_W-1:0]   pixel_h,
  output logic [PIX_V_W-1:0]   pixel_v,
  output logic                 busy,
  output logic                 frame_done
`ifdef RAY_DISPATCH_PERF_EN
  ,
  output logic [31:0]          frame_cycles
`endif
);

  localparam int unsigned        PTR_W   = $clog2(NUM_CORES);
  localparam logic [PIX_H_W-1:0] LAST_H  = PIX_H_W'(WIDTH - 1);
  localparam logic [PIX_V_W-1:0] LAST_V  = PIX_V_W'(HEIGHT - 1);
  localparam logic [PTR_W-1:0]   PTR_RST = PTR_W'(NUM_CORES - 1);

  state_e               state_q, state_d;
  logic [NUM_CORES-1:0] valid_q, valid_d;
  logic [PIX_H_W-1:0]   pix_h_q, pix_h_d;
  logic [PIX_V_W-1:0]   pix_v_q, pix_v_d;
  logic [PIX_H_W-1:0]   cnt_h_q, cnt_h_d;
  logic [PIX_V_W-1:0]   cnt_v_q, cnt_v_d;
  logic [PTR_W-1:0]     rr_q, rr_d;
  logic                 done_q, done_d;

  logic                 xfer;
  logic [PTR_W-1:0]     xfer_idx;
  logic [PTR_W-1:0]     arb_last;
  logic [NUM_CORES-1:0] grant;
  logic                 last_job;

  // Detect a transfer of the pending offer and which core took it.
  always_comb begin
    xfer     = |(valid_q & core_ready);
    xfer_idx = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (valid_q[i]) xfer_idx = PTR_W'(i);
    end
    // A core taking the offer this cycle becomes the last grant for the
    // follow-on offer computed in the same cycle.
    arb_last = xfer ? xfer_idx : rr_q;
    last_job = (pix_h_q == LAST_H) && (pix_v_q == LAST_V);
  end

  rr_arbiter #(
    .N     (NUM_CORES),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req      (core_ready),
    .last_ptr (arb_last),
    .grant    (grant)
  );

  // Next-state logic for the FSM, offer registers and scan counter.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    pix_h_d = pix_h_q;
    pix_v_d = pix_v_q;
    cnt_h_d = cnt_h_q;
    cnt_v_d = cnt_v_q;
    rr_d    = xfer ? xfer_idx : rr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = ISSUE;
          valid_d = '0;
          cnt_h_d = '0;
          cnt_v_d = '0;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
          valid_d = '0;
        end else if (xfer && last_job) begin
          state_d = DRAIN;
          valid_d = '0;
        end else if (!(|valid_q) || xfer) begin
          // The counter only advances when an offer is actually placed,
          // so a cycle with no ready core retries the same coordinate.
          valid_d = grant;
          if (|grant) begin
            pix_h_d = cnt_h_q;
            pix_v_d = cnt_v_q;
            if (cnt_v_q == LAST_V) begin
              cnt_v_d = '0;
              cnt_h_d = cnt_h_q + 1'b1;
            end else begin
              cnt_v_d = cnt_v_q + 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (&core_idle) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = '0;
      end
    endcase
  end

  // State and offer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      pix_h_q <= '0;
      pix_v_q <= '0;
      cnt_h_q <= '0;
      cnt_v_q <= '0;
      rr_q    <= PTR_RST;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      pix_h_q <= pix_h_d;
      pix_v_q <= pix_v_d;
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
      rr_q    <= rr_d;
      done_q  <= done_d;
    end
  end

  assign issue_valid = valid_q;
  assign pixel_h     = pix_h_q;
  assign pixel_v     = pix_v_q;
  assign busy        = (state_q != IDLE);
  assign frame_done  = done_q;

`ifdef RAY_DISPATCH_PERF_EN
  logic [31:0] cyc_q, cyc_d;

  // Busy-cycle counter: cleared on frame start, saturating.
  always_comb begin
    cyc_d = cyc_q;
    if (state_q == IDLE) begin
      if (start && !abort) cyc_d = '0;
    end else if (cyc_q != '1) begin
      cyc_d = cyc_q + 1'b1;
    end
  end

  // Busy-cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end

  assign frame_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_ray_dispatcher.sv
// Self-checking bench for ray_dispatcher (WIDTH=4, HEIGHT=3, NUM_CORES=2).
// Expected jobs are queued when a frame is started and popped as the
// monitor observes transfers.
module tb_ray_dispatcher;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int NC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [NC-1:0] core_ready;
  logic [NC-1:0] core_idle;
  logic [NC-1:0] issue_valid;
  logic [10:0]   pixel_h;
  logic [9:0]    pixel_v;
  logic          busy;
  logic          frame_done;
`ifdef RAY_DISPATCH_PERF_EN
  logic [31:0]   frame_cycles;
`endif

  ray_dispatcher #(
    .WIDTH     (W),
    .HEIGHT    (H),
    .NUM_CORES (NC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .core_ready  (core_ready),
    .core_idle   (core_idle),
    .issue_valid (issue_valid),
    .pixel_h     (pixel_h),
    .pixel_v     (pixel_v),
    .busy        (busy),
    .frame_done  (frame_done)
`ifdef RAY_DISPATCH_PERF_EN
    ,
    .frame_cycles(frame_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int v;
    int core;
  } job_t;

  job_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  int   xfers = 0;
  int   dones = 0;
  int   first_xfer_cyc = 0;
  int   last_xfer_cyc = 0;
  int   done_cyc = 0;

  logic [NC-1:0] prev_valid = '0;
  logic [10:0]   prev_h = '0;
  logic [9:0]    prev_v = '0;
  logic          prev_xfer = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Transfer monitor / scoreboard consumer.
  always @(negedge clk) begin
    job_t it;
    if (rst_n) begin
      check("onehot", 32'($onehot0(issue_valid)), 32'd1);
      if (busy && prev_valid != '0 && !prev_xfer) begin
        check("hold_valid", 32'(issue_valid), 32'(prev_valid));
        check("hold_h", 32'(pixel_h), 32'(prev_h));
        check("hold_v", 32'(pixel_v), 32'(prev_v));
      end
      if ((issue_valid & core_ready) != '0) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          it = sb.pop_front();
          check("job_h", 32'(pixel_h), 32'(it.h));
          check("job_v", 32'(pixel_v), 32'(it.v));
          check("job_core", issue_valid[1] ? 32'd1 : 32'd0, 32'(it.core));
          if (it.h == 0 && it.v == 0) first_xfer_cyc <= cyc;
        end
        xfers         <= xfers + 1;
        last_xfer_cyc <= cyc;
      end
      if (frame_done) begin
        dones    <= dones + 1;
        done_cyc <= cyc;
      end
    end
    prev_valid <= issue_valid;
    prev_xfer  <= |(issue_valid & core_ready);
    prev_h     <= pixel_h;
    prev_v     <= pixel_v;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame(input int first_core, input bit alternate);
    job_t j;
    int   k = 0;
    for (int hh = 0; hh < W; hh++) begin
      for (int vv = 0; vv < H; vv++) begin
        j.h    = hh;
        j.v    = vv;
        j.core = alternate ? ((first_core + k) % NC) : first_core;
        sb.push_back(j);
        k++;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int bound, input string tag);
    int n = 0;
    while (dones == base && n < bound) begin
      tick(1);
      n++;
    end
    check(tag, 32'(dones), 32'(base + 1));
  endtask

  task automatic wait_xfers(input int target, input int bound, input string tag);
    int n = 0;
    while (xfers < target && n < bound) begin
      tick(1);
      n++;
    end
    check(tag, 32'(xfers), 32'(target));
  endtask

  initial begin
    int s, x0, d0, n;
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    core_ready = '0;
    core_idle  = '1;
    #3;
    check("rst_valid", 32'(issue_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_h", 32'(pixel_h), 32'd0);
    check("rst_v", 32'(pixel_v), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
`ifdef RAY_DISPATCH_PERF_EN
    check("rst_cycles", frame_cycles, 32'd0);
`endif
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Full frame, all cores ready and idle.
    core_ready = 2'b11;
    core_idle  = 2'b11;
    push_frame(0, 1'b1);
    x0 = xfers;
    d0 = dones;
    s  = cyc;
    pulse_start();
    wait_done(d0, 40, "t1_done");
    check("t1_xfers", 32'(xfers - x0), 32'd12);
    check("t1_first_cyc", 32'(first_xfer_cyc - s), 32'd2);
    check("t1_last_cyc", 32'(last_xfer_cyc - s), 32'd13);
    check("t1_done_cyc", 32'(done_cyc - s), 32'd15);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
`ifdef RAY_DISPATCH_PERF_EN
    check("t1_cycles", frame_cycles, 32'd14);
`endif
    tick(3);
    check("t1_one_pulse", 32'(dones - d0), 32'd1);
`ifdef RAY_DISPATCH_PERF_EN
    check("t1_cycles_held", frame_cycles, 32'd14);
`endif

    // Core 1 never ready, core 0 toggles randomly.
    push_frame(0, 1'b0);
    x0 = xfers;
    d0 = dones;
    core_ready = 2'b00;
    pulse_start();
    n = 0;
    while (dones == d0 && n < 300) begin
      core_ready = {1'b0, 1'($urandom_range(0, 1))};
      tick(1);
      n++;
    end
    check("t2_done", 32'(dones), 32'(d0 + 1));
    check("t2_xfers", 32'(xfers - x0), 32'd12);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Drain held by a busy core; pointer persists (last grant was core 0).
    core_ready = 2'b11;
    core_idle  = 2'b01;
    push_frame(1, 1'b1);
    x0 = xfers;
    d0 = dones;
    pulse_start();
    wait_xfers(x0 + 12, 40, "t3_xfers");
    tick(5);
    check("t3_busy_drain", 32'(busy), 32'd1);
    check("t3_no_done", 32'(dones), 32'(d0));
    core_idle = 2'b11;
    wait_done(d0, 10, "t3_done");
    tick(2);
    check("t3_one_pulse", 32'(dones), 32'(d0 + 1));
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Abort after the fifth transfer, then restart from (0,0).
    push_frame(1, 1'b1);
    x0 = xfers;
    d0 = dones;
    pulse_start();
    wait_xfers(x0 + 5, 40, "t4_five");
    abort      = 1'b1;
    core_ready = 2'b00;
    tick(1);
    abort = 1'b0;
    check("t4_valid", 32'(issue_valid), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    tick(3);
    check("t4_no_done", 32'(dones), 32'(d0));
    check("t4_leftover", 32'(sb.size()), 32'd7);
    sb.delete();
    core_ready = 2'b11;
    push_frame(0, 1'b1);
    x0 = xfers;
    pulse_start();
    wait_done(d0, 40, "t4_restart_done");
    check("t4_restart_xfers", 32'(xfers - x0), 32'd12);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);

    // Start while busy is ignored; async reset mid-frame.
    push_frame(0, 1'b1);
    pulse_start();
    tick(3);
    pulse_start();
    check("t5_busy", 32'(busy), 32'd1);
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(issue_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_h", 32'(pixel_h), 32'd0);
    check("t5_rst_v", 32'(pixel_v), 32'd0);
    check("t5_rst_done", 32'(frame_done), 32'd0);
`ifdef RAY_DISPATCH_PERF_EN
    check("t5_rst_cycles", frame_cycles, 32'd0);
`endif
    sb.delete();
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // After reset the pointer restarts at core 0.
    push_frame(0, 1'b1);
    x0 = xfers;
    d0 = dones;
    pulse_start();
    wait_done(d0, 40, "t6_done");
    check("t6_xfers", 32'(xfers - x0), 32'd12);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
